// File: rtl/lcd_ctrl_if.sv
// ---------------------------------------------------------------------------
// lcd_ctrl_if
//   Write-request channel between the CPU-side MMIO adapter and lcd_ctrl.
//   A byte moves on a rising clock edge where req_valid and req_ready are
//   both high.
//
//   req_valid  master -> slave  request present
//   req_ready  slave  -> master controller accepts a request this cycle
//   req_rs     master -> slave  0 = command byte, 1 = character data
//   req_data   master -> slave  byte to write
// ---------------------------------------------------------------------------
interface lcd_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (
    output req_valid,
    output req_rs,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rs,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/lcd_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_ctrl
//   Write-only driver for an HD44780-compatible 8-bit character LCD. After
//   reset it waits out the panel power-up time, sends the fixed init
//   sequence (function set, display on, clear, entry mode) and then accepts
//   command/data bytes from the request channel, producing setup, enable,
//   hold and execution-time spacing for each byte.
//
//   clk_i        system clock
//   rst_i        asynchronous reset, active-high
//   req          request channel (slave side): valid/ready/rs/data
//   busy_o       inverse of req.req_ready, for CPU status polling
//   init_done_o  init sequence finished; sticky until reset
//   lcd_on_o     LCD power enable, high from the first edge after reset
//   lcd_en_o     LCD EN strobe (registered, glitch-free)
//   lcd_rs_o     LCD register select
//   lcd_rw_o     LCD R/W, always 0
//   lcd_data_o   LCD data bus
// ---------------------------------------------------------------------------
module lcd_ctrl #(
  parameter int SETUP_CYC      = 3,
  parameter int EN_CYC         = 12,
  parameter int HOLD_CYC       = 3,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int PWRUP_CYC      = 750000,
  parameter int CNT_W          = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  lcd_ctrl_if.slave        req,
  output logic             busy_o,
  output logic             init_done_o,
  output logic             lcd_on_o,
  output logic             lcd_en_o,
  output logic             lcd_rs_o,
  output logic             lcd_rw_o,
  output logic [7:0]       lcd_data_o
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  // The timer counts up from 0 on state entry; a state ends on the cycle
  // where the timer reaches its length minus one.
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             on_q, on_d;

  logic             ready;
  logic [CNT_W-1:0] wait_last;

  // Power-up init commands: 8-bit/2-line/5x8, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = 8'h38;
      2'd1:    cmd = 8'h0C;
      2'd2:    cmd = 8'h01;
      default: cmd = 8'h06;
    endcase
    return cmd;
  endfunction

  assign ready = (state_q == S_IDLE) && done_q;

  // Clear display and return home (commands 0x01..0x03) need the long
  // execution time; everything else gets the short one.
  assign wait_last = (!rs_q && (data_q inside {[8'h01:8'h03]})) ? LONG_LAST : SHORT_LAST;

  // Next-state logic. The pins are only reloaded on LOAD or on an accepted
  // request, so the last byte stays on the bus between transfers.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    done_d  = done_q;
    rs_d    = rs_q;
    data_d  = data_q;
    on_d    = 1'b1;

    unique case (state_q)
      S_PWRUP: begin
        if (timer_q == PWRUP_LAST) begin
          idx_d   = 2'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rs_d    = 1'b0;
        data_d  = init_cmd(idx_q);
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (timer_q == SETUP_LAST) state_d = S_PULSE;
      end
      S_PULSE: begin
        if (timer_q == EN_LAST) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (timer_q == HOLD_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q == wait_last) begin
          if (done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_IDLE: begin
        // Park the timer so it cannot wrap during a long idle period.
        timer_d = timer_q;
        if (req.req_valid && ready) begin
          rs_d    = req.req_rs;
          data_d  = req.req_data;
          state_d = S_SETUP;
        end
      end
      default: begin
        state_d = S_PWRUP;
      end
    endcase

    if (state_d != state_q) timer_d = '0;

    // EN is registered from the next state so it is high exactly while the
    // FSM sits in PULSE.
    en_d = (state_d == S_PULSE);
  end

  // State and pin registers; reset forces EN low immediately and restarts
  // the whole power-up sequence.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_PWRUP;
      timer_q <= '0;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      on_q    <= on_d;
    end
  end

  assign req.req_ready = ready;
  assign busy_o        = ~ready;
  assign init_done_o   = done_q;
  assign lcd_on_o      = on_q;
  assign lcd_en_o      = en_q;
  assign lcd_rs_o      = rs_q;
  assign lcd_rw_o      = 1'b0;
  assign lcd_data_o    = data_q;

endmodule
